dabble_counter: RTL and testbench
=================================

DABBLE_COUNTER -- requirements
Module: dabble_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of 4-bit display digits.
REQ-002 SHALL have parameter BIN_WIDTH, default 12: binary counter width; legal only if BIN_WIDTH == 4*DIGITS.
REQ-003 SHALL have parameter PRESCALE_BITS, default 23: count tick period is 2^PRESCALE_BITS enabled clk cycles.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = prescaler runs; 0 = prescaler and count hold.
REQ-007 clear  input  1  synchronous clear of count and prescaler.
REQ-008 mode  input  1  0 = hex display (wrap at 16^DIGITS-1), 1 = decimal BCD display (wrap at 10^DIGITS-1).
REQ-009 count  output  BIN_WIDTH  current binary count.
REQ-010 digits  output  4*DIGITS  displayed digits, digit 0 (ones) in bits [3:0], feeds SevenSeg.
REQ-011 valid  output  1  one-cycle pulse when digits updates.
REQ-012 wrap  output  1  one-cycle pulse on the edge count wraps to 0.
REQ-013 busy  output  1  high while a decimal conversion is in progress.

Function
REQ-014 Prescaler SHALL increment each edge with enable=1; at value 2^PRESCALE_BITS-1 it SHALL return to 0 and generate a tick on that same edge.
REQ-015 On tick, count SHALL become count+1, or 0 with wrap=1 for one cycle if count equals the current mode's maximum (999 or 0xFFF for defaults).
REQ-016 Hex mode: digits SHALL load the new count on the same edge as the count update; valid pulses that cycle; busy stays 0.
REQ-017 Decimal mode: FSM states IDLE, SHIFT, DONE; a count update SHALL move IDLE->SHIFT, loading shift register with the new count, BCD accumulator 0, iteration counter 0.
REQ-018 SHIFT: each edge, every BCD nibble >= 5 SHALL add 3, then {bcd,shreg} shifts left 1; after BIN_WIDTH shifts FSM SHALL enter DONE.
REQ-019 DONE: digits SHALL load the BCD accumulator, valid pulses one cycle, FSM returns to IDLE; digits therefore update BIN_WIDTH+1 edges after the count update.
REQ-020 busy SHALL be 1 exactly while FSM is in SHIFT or DONE.
REQ-021 Count update while busy SHALL set a pending flag; at DONE the FSM SHALL go to SHIFT with the latest count instead of IDLE (digits from the stale conversion still load, valid still pulses).
REQ-022 A mode change (mode differs from previous-cycle mode) SHALL trigger a refresh: in decimal, if count > 10^DIGITS-1, count SHALL clear to 0 (no wrap pulse); then hex load or decimal conversion per REQ-016/017.
REQ-023 clear=1 SHALL, on that edge, zero count, prescaler and digits, abort any conversion (FSM IDLE, pending 0), pulse valid; clear overrides tick and enable.
REQ-024 With enable=0 no ticks occur; an in-progress conversion SHALL still complete.
REQ-025 Digits SHALL change only on edges where valid=1; no intermediate BCD values appear on digits.

Reset
REQ-026 reset=1 SHALL immediately force count=0, prescaler=0, digits=0, valid=0, wrap=0, busy=0, FSM IDLE, pending=0, previous-mode register=mode-low default 0, regardless of clk.
REQ-027 Reset asserted mid-conversion SHALL discard it; after release, first count update starts a fresh conversion.

Verification (DIGITS=3, BIN_WIDTH=12, PRESCALE_BITS=4)
REQ-028 Reset, mode=1, enable=1 -> first tick after 16 cycles, count=1, digits=0x001 exactly 13 edges later with one valid pulse, busy high 13 cycles.
REQ-029 Decimal, count forced to 998 by ticking -> next tick count=999, digits=0x999; following tick count=0, wrap pulse, digits=0x000.
REQ-030 Hex mode, count at 0x0FF -> tick gives count=0x100, digits=0x100 same edge, valid same cycle, busy 0; at 0xFFF tick -> 0, wrap=1.
REQ-031 Hex count=0xABC (2748), switch mode to 1 -> count cleared to 0, digits=0x000 after conversion; from decimal 0x2A (42) switch to hex -> digits=0x02A next edge.
REQ-032 PRESCALE_BITS=2 decimal: tick during SHIFT -> pending set, stale digits load, then second conversion yields latest count in BCD, two valid pulses.
REQ-033 Assert clear mid-conversion, and separately assert reset mid-conversion -> count=0, digits=0, busy=0 immediately (clear: that edge; reset: asynchronously); no late valid from aborted conversion.

Source files
------------

// File: rtl/dabble_counter.sv
// -----------------------------------------------------------------------------
// dabble_counter
//
// Free-running display counter with a hex or decimal (BCD) digit output.
// A prescaler divides clk by 2^PRESCALE_BITS while enable is high; each
// prescaler rollover advances the binary count. In hex mode the display digits
// follow the count directly. In decimal mode the count is converted to BCD
// with a sequential double-dabble engine (one bit per clock). The digits only
// ever show a finished result.
//
// BIN_WIDTH must equal 4*DIGITS. Decimal mode wraps at 10^DIGITS-1 and hex
// mode wraps at 16^DIGITS-1.
//
// Ports
//   clk     in   sole clock, rising edge
//   reset   in   asynchronous, active-high reset
//   enable  in   1 = prescaler runs, 0 = prescaler and count hold
//   clear   in   synchronous clear of count, prescaler, digits and conversion
//   mode    in   0 = hex display, 1 = decimal BCD display
//   count   out  current binary count
//   digits  out  displayed digits, digit 0 (ones) in [3:0]
//   valid   out  one-cycle pulse on the cycle digits has just been updated
//   wrap    out  one-cycle pulse after the count wraps to 0
//   busy    out  high while a decimal conversion is in progress
//
// Conversion FSM
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no conversion running, waiting for a count update
//   ST_SHIFT | add-3 / shift-left, one binary bit per clock, BIN_WIDTH clocks
//   ST_DONE  | BCD result loads onto digits; restart if an update is pending
// -----------------------------------------------------------------------------
module dabble_counter #(
   parameter int DIGITS        = 3,
   parameter int BIN_WIDTH     = 12,
   parameter int PRESCALE_BITS = 23
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  mode,
   output logic [BIN_WIDTH-1:0]  count,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  valid,
   output logic                  wrap,
   output logic                  busy
);

   localparam int DW = 4 * DIGITS;
   localparam int IW = $clog2(BIN_WIDTH + 1);

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

   localparam logic [BIN_WIDTH-1:0] HEX_MAX   = '1;
   localparam logic [BIN_WIDTH-1:0] DEC_MAX   = BIN_WIDTH'(pow10(DIGITS) - 1);
   localparam logic [IW-1:0]        ITER_LAST = IW'(BIN_WIDTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [PRESCALE_BITS-1:0]  presc;
   logic                      mode_q;
   logic [1:0]                state;
   logic                      pending;
   logic [BIN_WIDTH-1:0]      shreg;
   logic [DW-1:0]             bcd;
   logic [IW-1:0]             iter;

   logic                      tick;
   logic                      mode_chg;
   logic                      upd;
   logic [BIN_WIDTH-1:0]      cur_max;
   logic                      at_max;
   logic [BIN_WIDTH-1:0]      count_tick;
   logic [BIN_WIDTH-1:0]      count_next;
   logic [DW-1:0]             bcd_adj;
   logic [DW+BIN_WIDTH-1:0]   shifted;

   // ---------------------------------------------------------------------
   // Next-count logic
   // ---------------------------------------------------------------------
   assign tick     = enable && (presc == '1);
   assign mode_chg = mode ^ mode_q;
   assign upd      = tick || mode_chg;
   assign cur_max  = mode ? DEC_MAX : HEX_MAX;
   assign at_max   = (count == cur_max);

   always_comb begin
      count_tick = count;
      if (tick) begin
         count_tick = at_max ? '0 : count + 1'b1;
      end
   end

   // Entering decimal with a count that cannot be shown in DIGITS decimal
   // digits forces the count back to 0; this is not a wrap.
   always_comb begin
      count_next = count_tick;
      if (mode_chg && mode && (count_tick > DEC_MAX)) begin
         count_next = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Double-dabble datapath: add 3 to every nibble >= 5, then shift left
   // ---------------------------------------------------------------------
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   assign shifted = {bcd_adj, shreg} << 1;

   // ---------------------------------------------------------------------
   // Prescaler
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (clear) begin
         presc <= '0;
      end else if (enable) begin
         presc <= presc + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Binary count and wrap pulse
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (clear) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_next;
         wrap  <= tick && at_max;
      end
   end

   // ---------------------------------------------------------------------
   // Previous-cycle mode, used to detect a display-mode switch
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q <= 1'b0;
      end else begin
         mode_q <= mode;
      end
   end

   // ---------------------------------------------------------------------
   // Conversion FSM. Hex mode keeps it parked in IDLE, so switching to hex
   // abandons any decimal result still in flight.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         pending <= 1'b0;
         shreg   <= '0;
         bcd     <= '0;
         iter    <= '0;
      end else if (clear || !mode) begin
         state   <= ST_IDLE;
         pending <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (upd) begin
                  state <= ST_SHIFT;
                  shreg <= count_next;
                  bcd   <= '0;
                  iter  <= '0;
               end
            end
            ST_SHIFT: begin
               bcd   <= shifted[DW+BIN_WIDTH-1:BIN_WIDTH];
               shreg <= shifted[BIN_WIDTH-1:0];
               iter  <= iter + 1'b1;
               if (iter == ITER_LAST) begin
                  state <= ST_DONE;
               end
               if (upd) begin
                  pending <= 1'b1;
               end
            end
            ST_DONE: begin
               pending <= 1'b0;
               // The count moved on while converting: start over from the
               // newest value rather than idling with a stale display.
               if (pending || upd) begin
                  state <= ST_SHIFT;
                  shreg <= count_next;
                  bcd   <= '0;
                  iter  <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               pending <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

   // ---------------------------------------------------------------------
   // Display register: only ever written together with a valid pulse
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits <= '0;
         valid  <= 1'b0;
      end else if (clear) begin
         digits <= '0;
         valid  <= 1'b1;
      end else if (!mode && upd) begin
         digits <= count_next;
         valid  <= 1'b1;
      end else if (mode && (state == ST_DONE)) begin
         digits <= bcd;
         valid  <= 1'b1;
      end else begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dabble_counter.sv
// -----------------------------------------------------------------------------
// Bench for dabble_counter. Two instances share one clock:
//   u_dut1 : PRESCALE_BITS=4 (tick every 16 clocks), decimal-focused checks
//   u_dut2 : PRESCALE_BITS=2 (tick every 4 clocks), pending and hex checks
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dabble_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset1 = 1'b0, enable1 = 1'b0, clear1 = 1'b0, mode1 = 1'b0;
   logic [11:0] count1, digits1;
   logic        valid1, wrap1, busy1;

   logic        reset2 = 1'b0, enable2 = 1'b0, clear2 = 1'b0, mode2 = 1'b0;
   logic [11:0] count2, digits2;
   logic        valid2, wrap2, busy2;

   dabble_counter #(.DIGITS(3), .BIN_WIDTH(12), .PRESCALE_BITS(4)) u_dut1 (
      .clk(clk), .reset(reset1), .enable(enable1), .clear(clear1), .mode(mode1),
      .count(count1), .digits(digits1), .valid(valid1), .wrap(wrap1), .busy(busy1)
   );

   dabble_counter #(.DIGITS(3), .BIN_WIDTH(12), .PRESCALE_BITS(2)) u_dut2 (
      .clk(clk), .reset(reset2), .enable(enable2), .clear(clear2), .mode(mode2),
      .count(count2), .digits(digits2), .valid(valid2), .wrap(wrap2), .busy(busy2)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [11:0] cnt(input int s);
      return (s == 1) ? count1 : count2;
   endfunction
   function automatic logic [11:0] dig(input int s);
      return (s == 1) ? digits1 : digits2;
   endfunction
   function automatic logic vld(input int s);
      return (s == 1) ? valid1 : valid2;
   endfunction
   function automatic logic bsy(input int s);
      return (s == 1) ? busy1 : busy2;
   endfunction

   // Wait (bounded) until the count reaches target; the final compare also
   // reports an expired budget.
   task automatic wait_cnt(input int s, input logic [11:0] target, input int budget,
                           input string tag);
      int n;
      n = 0;
      while (cnt(s) !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, cnt(s), target);
   endtask

   // Observe 16 samples starting with the current one (sample 0 = just after
   // the count update edge).
   task automatic conv_window(input int s, output int nv, output int idx,
                              output logic [11:0] d, output int nb);
      nv  = 0;
      idx = -1;
      d   = 'x;
      nb  = 0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         if (bsy(s)) nb++;
         if (vld(s)) begin
            if (nv == 0) begin
               idx = i;
               d   = dig(s);
            end
            nv++;
         end
      end
   endtask

   // Digits may only change on a cycle where valid is high (outside reset).
   int          viol = 0;
   logic [11:0] pd1, pd2;
   always @(negedge clk) begin
      if (digits1 !== pd1 && !valid1 && !reset1) viol++;
      if (digits2 !== pd2 && !valid2 && !reset2) viol++;
      pd1 <= digits1;
      pd2 <= digits2;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, nv, idx, nb, idx1, idx2;
      logic [11:0] d, d1, d2;

      mode1   = 1'b1;
      enable1 = 1'b1;
      mode2   = 1'b1;
      enable2 = 1'b0;
      #1;
      reset1 = 1'b1;
      reset2 = 1'b1;
      #1;
      check("rst_count",  count1, 12'h000);
      check("rst_digits", digits1, 12'h000);
      check("rst_valid",  valid1, 1'b0);
      check("rst_wrap",   wrap1, 1'b0);
      check("rst_busy",   busy1, 1'b0);
      check("rst_busy2",  busy2, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset1 = 1'b0;
      reset2 = 1'b0;

      // First tick after 16 enabled edges, then 0x001 13 edges later
      n = 0;
      while (count1 !== 12'd1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("first_tick_edges", n, 16);
      conv_window(1, nv, idx, d, nb);
      check("first_nvalid", nv, 1);
      check("first_valid_idx", idx, 13);
      check("first_digits", d, 12'h001);
      check("first_busy_cycles", nb, 13);

      // Decimal 42 -> hex switch shows 0x02A on the next edge
      wait_cnt(1, 12'd42, 41*16+8, "reach_42");
      repeat (14) @(negedge clk);
      check("dec42_digits", digits1, 12'h042);
      mode1 = 1'b0;
      @(negedge clk);
      check("hex42_digits", digits1, 12'h02A);
      check("hex42_valid", valid1, 1'b1);
      check("hex42_busy", busy1, 1'b0);
      mode1 = 1'b1;

      // Decimal top: 998 -> 999 -> 0 with wrap
      wait_cnt(1, 12'd998, 960*16, "reach_998");
      wait_cnt(1, 12'd999, 20, "tick_999");
      conv_window(1, nv, idx, d, nb);
      check("d999_digits", d, 12'h999);
      check("d999_idx", idx, 13);
      wait_cnt(1, 12'd0, 20, "dec_wrap_cnt");
      check("dec_wrap_pulse", wrap1, 1'b1);
      conv_window(1, nv, idx, d, nb);
      check("dec_wrap_digits", d, 12'h000);
      check("dec_wrap_nvalid", nv, 1);
      check("dec_wrap_gone", wrap1, 1'b0);

      // Clear mid-conversion
      wait_cnt(1, 12'd1, 20, "clr_cnt1");
      wait_cnt(1, 12'd2, 20, "clr_cnt2");
      repeat (3) @(negedge clk);
      check("clr_pre_digits", digits1, 12'h001);
      enable1 = 1'b0;
      clear1  = 1'b1;
      @(negedge clk);
      clear1 = 1'b0;
      check("clr_count", count1, 12'h000);
      check("clr_digits", digits1, 12'h000);
      check("clr_busy", busy1, 1'b0);
      check("clr_valid", valid1, 1'b1);
      nv = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid1) nv++;
      end
      check("clr_no_late_valid", nv, 0);

      // Reset mid-conversion (asynchronous)
      enable1 = 1'b1;
      wait_cnt(1, 12'd1, 20, "rstm_cnt1");
      wait_cnt(1, 12'd2, 20, "rstm_cnt2");
      repeat (3) @(negedge clk);
      check("rstm_pre_busy", busy1, 1'b1);
      reset1 = 1'b1;
      mode1  = 1'b0;
      #1;
      check("rstm_count", count1, 12'h000);
      check("rstm_digits", digits1, 12'h000);
      check("rstm_busy", busy1, 1'b0);
      check("rstm_valid", valid1, 1'b0);
      enable1 = 1'b0;
      repeat (2) @(negedge clk);
      reset1 = 1'b0;
      nv = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid1) nv++;
      end
      check("rstm_no_late_valid", nv, 0);
      check("rstm_digits_hold", digits1, 12'h000);

      // Pending: second tick lands during SHIFT (PRESCALE_BITS=2)
      check("p_idle_digits", digits2, 12'h000);
      enable2 = 1'b1;
      wait_cnt(2, 12'd1, 8, "p_cnt1");
      wait_cnt(2, 12'd2, 8, "p_cnt2");
      enable2 = 1'b0;
      check("p_busy", busy2, 1'b1);
      nv = 0; idx1 = -1; idx2 = -1; d1 = 'x; d2 = 'x;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         if (valid2) begin
            if (nv == 0) begin idx1 = i; d1 = digits2; end
            if (nv == 1) begin idx2 = i; d2 = digits2; end
            nv++;
         end
      end
      check("p_nvalid", nv, 2);
      check("p_stale_idx", idx1, 9);
      check("p_stale_digits", d1, 12'h001);
      check("p_latest_idx", idx2, 22);
      check("p_latest_digits", d2, 12'h002);

      // Hex mode
      mode2 = 1'b0;
      @(negedge clk);
      check("hex_refresh_digits", digits2, 12'h002);
      check("hex_refresh_valid", valid2, 1'b1);
      enable2 = 1'b1;
      wait_cnt(2, 12'h0FF, 260*4, "reach_0ff");
      check("hex_0ff_digits", digits2, 12'h0FF);
      wait_cnt(2, 12'h100, 8, "tick_100");
      check("hex_100_digits", digits2, 12'h100);
      check("hex_100_valid", valid2, 1'b1);
      check("hex_100_busy", busy2, 1'b0);
      wait_cnt(2, 12'hFFF, (4096-256)*4+16, "reach_fff");
      wait_cnt(2, 12'h000, 8, "hex_wrap_cnt");
      check("hex_wrap_pulse", wrap2, 1'b1);
      check("hex_wrap_digits", digits2, 12'h000);
      check("hex_wrap_valid", valid2, 1'b1);

      // Hex 0xABC -> decimal: out of range, count clears, converts 0
      wait_cnt(2, 12'hABC, 2748*4+16, "reach_abc");
      check("hex_abc_digits", digits2, 12'hABC);
      mode2   = 1'b1;
      enable2 = 1'b0;
      @(negedge clk);
      check("abc_clear_count", count2, 12'h000);
      check("abc_no_wrap", wrap2, 1'b0);
      check("abc_busy", busy2, 1'b1);
      conv_window(2, nv, idx, d, nb);
      check("abc_digits", d, 12'h000);
      check("abc_idx", idx, 13);
      check("abc_nvalid", nv, 1);

      check("dig_stable", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
